// File: rtl/fp_pkg.sv
// Shared types, constants and operand classifiers for the single-precision
// divider datapath.
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP_QNAN    = 32'h7fc00000;
  localparam logic [7:0]  FP_INF_EXP = 8'hff;
  localparam int          BIAS       = 127;
  localparam int          QW         = 27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } fp_div_state_t;

  // NaN: all-ones exponent with a nonzero fraction.
  function automatic logic is_nan(input fp32_t x);
    return (x.exp == FP_INF_EXP) && (x.frac != 23'd0);
  endfunction

  // Infinity: all-ones exponent with a zero fraction.
  function automatic logic is_inf(input fp32_t x);
    return (x.exp == FP_INF_EXP) && (x.frac == 23'd0);
  endfunction

  // Zero exponent: true zero or a denormal, which is flushed to zero.
  function automatic logic is_zero(input fp32_t x);
    return (x.exp == 8'd0);
  endfunction

endpackage

// File: rtl/fp_mant_div_iter.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first.
// A start pulse loads the operands; QW cycles later done rises and q holds
// floor(ma * 2^(QW-1) / mb). rem is the final partial remainder (shifted),
// which is nonzero exactly when the division was inexact.
module fp_mant_div_iter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic        busy,
  output logic        done,
  output logic [26:0] q,
  output logic [24:0] rem
);

  logic [23:0] mb_r;
  logic [24:0] rem_r;
  logic [26:0] q_r;
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic        done_r;

  logic        ge_s;
  logic [24:0] diff_s;
  logic [24:0] nr_s;

  // Trial subtraction of the divisor from the current partial remainder.
  always_comb begin
    ge_s   = 1'b0;
    diff_s = 25'd0;
    nr_s   = rem_r;
    diff_s = rem_r - {1'b0, mb_r};
    if (rem_r >= {1'b0, mb_r}) begin
      ge_s = 1'b1;
      nr_s = diff_s;
    end else begin
      ge_s = 1'b0;
      nr_s = rem_r;
    end
  end

  // Operand load on start, then one restoring step per cycle until QW bits exist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_r   <= 24'd0;
      rem_r  <= 25'd0;
      q_r    <= 27'd0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      mb_r   <= mb;
      rem_r  <= {1'b0, ma};
      q_r    <= 27'd0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      rem_r <= nr_s << 1;
      q_r   <= {q_r[25:0], ge_s};
      if (cnt_r == 5'(QW - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = q_r;
  assign rem  = rem_r;

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider y = a / b.
// Special operands resolve at accept and go straight to DONE; normal operands
// run through the iterative mantissa divider, then one round-to-nearest-even
// cycle. Denormal inputs are flushed to zero and no denormal is produced.
module fp_divider_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        dz
);

  fp_div_state_t state_r, state_n;

  logic               in_ready_r;
  logic               out_valid_r;
  logic               dz_r;
  logic               sign_r;
  logic [31:0]        y_r;
  logic signed [9:0]  exp_r;

  logic               accept_s;
  logic               iter_start_s;
  logic               iter_busy_s;
  logic               iter_done_s;
  logic [26:0]        iter_q_s;
  logic [24:0]        iter_rem_s;

  fp32_t              fa_s;
  fp32_t              fb_s;
  logic               res_sign_s;
  logic signed [9:0]  exp_in_s;
  logic               special_s;
  logic [31:0]        spec_y_s;
  logic               spec_dz_s;

  logic [23:0]        m_pre_s;
  logic               g_s;
  logic               st_s;
  logic               inc_s;
  logic signed [9:0]  e_norm_s;
  logic signed [9:0]  e_rnd_s;
  logic [24:0]        m_sum_s;
  logic [23:0]        m_rnd_s;
  logic [31:0]        round_y_s;

  assign accept_s   = in_valid && in_ready_r;
  assign fa_s       = a;
  assign fb_s       = b;
  assign res_sign_s = a[31] ^ b[31];
  assign exp_in_s   = $signed({2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(BIAS));

  fp_mant_div_iter u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start_s),
    .ma    ({1'b1, a[22:0]}),
    .mb    ({1'b1, b[22:0]}),
    .busy  (iter_busy_s),
    .done  (iter_done_s),
    .q     (iter_q_s),
    .rem   (iter_rem_s)
  );

  // Classify operands and pick the early result for NaN/inf/zero cases.
  always_comb begin
    special_s = 1'b0;
    spec_y_s  = 32'd0;
    spec_dz_s = 1'b0;
    if (is_nan(fa_s) || is_nan(fb_s) ||
        (is_zero(fa_s) && is_zero(fb_s)) ||
        (is_inf(fa_s) && is_inf(fb_s))) begin
      special_s = 1'b1;
      spec_y_s  = FP_QNAN;
    end else if (is_inf(fa_s)) begin
      special_s = 1'b1;
      spec_y_s  = {res_sign_s, FP_INF_EXP, 23'd0};
    end else if (is_zero(fb_s)) begin
      special_s = 1'b1;
      spec_y_s  = {res_sign_s, FP_INF_EXP, 23'd0};
      spec_dz_s = 1'b1;
    end else if (is_zero(fa_s) || is_inf(fb_s)) begin
      special_s = 1'b1;
      spec_y_s  = {res_sign_s, 31'd0};
    end else begin
      special_s = 1'b0;
    end
  end

  // Normalise the quotient, round to nearest even, then clamp the exponent range.
  always_comb begin
    m_pre_s   = 24'd0;
    g_s       = 1'b0;
    st_s      = 1'b0;
    e_norm_s  = exp_r;
    inc_s     = 1'b0;
    m_sum_s   = 25'd0;
    m_rnd_s   = 24'd0;
    e_rnd_s   = exp_r;
    round_y_s = 32'd0;
    if (iter_q_s[26]) begin
      m_pre_s  = iter_q_s[26:3];
      g_s      = iter_q_s[2];
      st_s     = (|iter_q_s[1:0]) | (|iter_rem_s);
      e_norm_s = exp_r;
    end else begin
      m_pre_s  = iter_q_s[25:2];
      g_s      = iter_q_s[1];
      st_s     = iter_q_s[0] | (|iter_rem_s);
      e_norm_s = exp_r - 10'sd1;
    end
    inc_s   = g_s && (st_s || m_pre_s[0]);
    m_sum_s = {1'b0, m_pre_s} + {24'd0, inc_s};
    if (m_sum_s[24]) begin
      m_rnd_s = 24'h800000;
      e_rnd_s = e_norm_s + 10'sd1;
    end else begin
      m_rnd_s = m_sum_s[23:0];
      e_rnd_s = e_norm_s;
    end
    if (e_rnd_s >= 10'sd255) begin
      round_y_s = {sign_r, FP_INF_EXP, 23'd0};
    end else if (e_rnd_s <= 10'sd0) begin
      round_y_s = {sign_r, 31'd0};
    end else begin
      round_y_s = {sign_r, e_rnd_s[7:0], m_rnd_s[22:0]};
    end
  end

  // Control FSM next-state and divider start decode.
  always_comb begin
    state_n      = state_r;
    iter_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (special_s) begin
            state_n = DONE;
          end else begin
            state_n      = DIVIDE;
            iter_start_s = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      DIVIDE: begin
        if (iter_done_s && !iter_busy_s) begin
          state_n = ROUND;
        end else begin
          state_n = DIVIDE;
        end
      end
      ROUND: begin
        state_n = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; in_ready is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == IDLE);
    end
  end

  // Operand capture at accept and result registers held until transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r      <= 1'b0;
      exp_r       <= 10'sd0;
      y_r         <= 32'd0;
      dz_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_r <= res_sign_s;
            exp_r  <= exp_in_s;
            if (special_s) begin
              y_r         <= spec_y_s;
              dz_r        <= spec_dz_s;
              out_valid_r <= 1'b1;
            end else begin
              dz_r <= 1'b0;
            end
          end
        end
        ROUND: begin
          y_r         <= round_y_s;
          dz_r        <= 1'b0;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign dz        = dz_r;

endmodule
